// File: rtl/viterbi_acs_array.sv
// Rate-1/2 Viterbi add-compare-select array with register-exchange survivor memory.
// Define VITERBI_PM_NORM_EN to clear the path-metric MSB whenever every new metric has it set.
module viterbi_acs_array #(
   parameter int             K         = 3,
   parameter logic [K-1:0]   G0        = 3'b111,
   parameter logic [K-1:0]   G1        = 3'b101,
   parameter int             BM_WIDTH  = 2,
   parameter int             PM_WIDTH  = 6,
   parameter int             SEQ_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  bm_valid,
   input  logic [4*BM_WIDTH-1:0] bm_in,
   output logic                  dec_valid,
   output logic                  dec_bit,
   output logic [K-2:0]          best_state,
   output logic [PM_WIDTH-1:0]   best_pm
);
   localparam int NS = 1 << (K - 1);
   localparam int CW = $clog2(SEQ_WIDTH + 1);
   localparam logic [CW-1:0]       FILL_MAX = CW'(SEQ_WIDTH);
   localparam logic [PM_WIDTH-1:0] PM_INIT  = {2'b01, {(PM_WIDTH-2){1'b0}}};

   logic [PM_WIDTH-1:0]  pm       [NS];
   logic [PM_WIDTH-1:0]  pm_acs   [NS];
   logic [PM_WIDTH-1:0]  pm_next  [NS];
   logic [SEQ_WIDTH-1:0] seq      [NS];
   logic [SEQ_WIDTH-1:0] seq_next [NS];
   logic [CW-1:0]        fill;
   logic                 upd_d;
   logic                 dec_pend;
   logic [K-2:0]         min_idx;
   logic [PM_WIDTH-1:0]  min_pm;

   // Trellis wiring is fixed by K and the generators, so predecessors and
   // branch symbols resolve to constants per destination state.
   for (genvar g = 0; g < NS; g++) begin : g_acs
      localparam logic [K-2:0] NSV = (K-1)'(g);
      localparam logic         BIT = NSV[K-2];
      localparam logic [K-2:0] P0  = {NSV[K-3:0], 1'b0};
      localparam logic [K-2:0] P1  = {NSV[K-3:0], 1'b1};
      localparam logic [K-1:0] R0  = {BIT, P0};
      localparam logic [K-1:0] R1  = {BIT, P1};
      localparam int S0 = 2 * int'(^(R0 & G0)) + int'(^(R0 & G1));
      localparam int S1 = 2 * int'(^(R1 & G0)) + int'(^(R1 & G1));

      logic [PM_WIDTH:0] m0;
      logic [PM_WIDTH:0] m1;
      logic [PM_WIDTH:0] msel;
      logic              take1;

      assign m0    = {1'b0, pm[P0]} + (PM_WIDTH+1)'(bm_in[S0*BM_WIDTH +: BM_WIDTH]);
      assign m1    = {1'b0, pm[P1]} + (PM_WIDTH+1)'(bm_in[S1*BM_WIDTH +: BM_WIDTH]);
      assign take1 = m1 < m0;
      assign msel  = take1 ? m1 : m0;
      assign pm_acs[g]   = msel[PM_WIDTH] ? '1 : msel[PM_WIDTH-1:0];
      assign seq_next[g] = take1 ? {seq[P1][SEQ_WIDTH-2:0], BIT}
                                 : {seq[P0][SEQ_WIDTH-2:0], BIT};
   end

`ifdef VITERBI_PM_NORM_EN
   logic [NS-1:0] acs_msb;
   logic          norm_all;

   always_comb begin
      for (int s = 0; s < NS; s++) begin
         acs_msb[s] = pm_acs[s][PM_WIDTH-1];
      end
   end

   assign norm_all = &acs_msb;

   always_comb begin
      for (int s = 0; s < NS; s++) begin
         pm_next[s] = norm_all ? {1'b0, pm_acs[s][PM_WIDTH-2:0]} : pm_acs[s];
      end
   end
`else
   always_comb begin
      pm_next = pm_acs;
   end
`endif

   // Lowest index wins ties because only a strictly smaller metric replaces the candidate.
   always_comb begin
      min_idx = '0;
      min_pm  = pm[0];
      for (int s = 1; s < NS; s++) begin
         if (pm[s] < min_pm) begin
            min_idx = (K-1)'(s);
            min_pm  = pm[s];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NS; s++) begin
            pm[s]  <= (s == 0) ? '0 : PM_INIT;
            seq[s] <= '0;
         end
         fill       <= '0;
         upd_d      <= 1'b0;
         dec_pend   <= 1'b0;
         dec_valid  <= 1'b0;
         dec_bit    <= 1'b0;
         best_state <= '0;
         best_pm    <= '0;
      end else if (start) begin
         for (int s = 0; s < NS; s++) begin
            pm[s]  <= (s == 0) ? '0 : PM_INIT;
            seq[s] <= '0;
         end
         fill       <= '0;
         upd_d      <= 1'b0;
         dec_pend   <= 1'b0;
         dec_valid  <= 1'b0;
         dec_bit    <= 1'b0;
         best_state <= '0;
         best_pm    <= '0;
      end else begin
         // Outputs lag the metric update by one cycle and are read from the registered array.
         dec_valid <= dec_pend;
         if (dec_pend) begin
            dec_bit <= seq[min_idx][SEQ_WIDTH-1];
         end
         if (upd_d) begin
            best_state <= min_idx;
            best_pm    <= min_pm;
         end
         upd_d    <= bm_valid;
         dec_pend <= bm_valid && (fill == FILL_MAX);
         if (bm_valid) begin
            pm  <= pm_next;
            seq <= seq_next;
            if (fill != FILL_MAX) begin
               fill <= fill + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_viterbi_acs_array.sv
// Bench for viterbi_acs_array: trellis model with traceback over stored decisions,
// compared every cycle against the registered outputs.
module tb_viterbi_acs_array;
   localparam int K      = 3;
   localparam int NS     = 4;
   localparam int BMW    = 2;
   localparam int PMW    = 6;
   localparam int SEQW   = 10;
   localparam int PM_MAX = 63;
   localparam int HIST   = 64;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic           bm_valid = 1'b0;
   logic [4*BMW-1:0] bm_in = '0;
   logic           dec_valid;
   logic           dec_bit;
   logic [K-2:0]   best_state;
   logic [PMW-1:0] best_pm;
   logic [9:0]     obs_vec;

   int n_checks = 0;
   int n_pass   = 0;

   int  m_pm   [NS];
   int  m_pred [HIST][NS];
   int  m_step;
   bit  m_upd_prev;
   int  m_dec_idx;
   bit  e_dv;
   bit  e_db;
   int  e_bs;
   int  e_bpm;

   viterbi_acs_array #(
      .K(3), .G0(3'b111), .G1(3'b101), .BM_WIDTH(2), .PM_WIDTH(6), .SEQ_WIDTH(10)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .bm_valid(bm_valid), .bm_in(bm_in),
      .dec_valid(dec_valid), .dec_bit(dec_bit), .best_state(best_state), .best_pm(best_pm)
   );

   always #5 clk = ~clk;

   assign obs_vec = {dec_valid, dec_bit, best_state, best_pm};

   function automatic int parity(input int x);
      return $countones(x) % 2;
   endfunction

   // Code symbol {c0,c1} emitted when input b leaves state p (G0=7, G1=5).
   function automatic int sym_of(input int p, input int b);
      int r;
      r = (b << (K - 1)) | p;
      return 2 * parity(r & 7) + parity(r & 5);
   endfunction

   function automatic int best_m();
      int bi;
      bi = 0;
      for (int s = 1; s < NS; s++) if (m_pm[s] < m_pm[bi]) bi = s;
      return bi;
   endfunction

   function automatic logic [9:0] exp_vec();
      return {e_dv, e_db, 2'(e_bs), 6'(e_bpm)};
   endfunction

   task automatic model_reset();
      m_pm[0] = 0;
      for (int s = 1; s < NS; s++) m_pm[s] = 16;
      m_step = 0;
      m_upd_prev = 0;
      m_dec_idx = -1;
      e_dv = 0; e_db = 0; e_bs = 0; e_bpm = 0;
   endtask

   task automatic model_edge(input bit st, input bit v, input logic [7:0] bm);
      int npm [NS];
      int bc  [NS];
      int pr  [NS];
      int bb, tst, ns, c;
`ifdef VITERBI_PM_NORM_EN
      bit all_hi;
`endif
      if (st) begin
         model_reset();
         return;
      end
      bb = best_m();
      e_dv = 0;
      if (m_dec_idx >= 0) begin
         tst = bb;
         for (int k = m_dec_idx; k > m_dec_idx - (SEQW - 1); k--) tst = m_pred[k % HIST][tst];
         e_dv = 1;
         e_db = ((tst >> (K - 2)) & 1) != 0;
      end
      if (m_upd_prev) begin
         e_bs  = bb;
         e_bpm = m_pm[bb];
      end
      m_upd_prev = v;
      m_dec_idx  = (v && m_step >= SEQW) ? m_step : -1;
      if (v) begin
         for (int s = 0; s < NS; s++) begin bc[s] = -1; pr[s] = 0; end
         for (int p = 0; p < NS; p++) begin
            for (int b = 0; b < 2; b++) begin
               ns = (b << (K - 2)) | (p >> 1);
               c  = m_pm[p] + int'((bm >> (2 * sym_of(p, b))) & 8'h03);
               if (bc[ns] < 0 || c < bc[ns]) begin
                  bc[ns] = c;
                  pr[ns] = p;
               end
            end
         end
         for (int s = 0; s < NS; s++) npm[s] = (bc[s] > PM_MAX) ? PM_MAX : bc[s];
`ifdef VITERBI_PM_NORM_EN
         all_hi = 1;
         for (int s = 0; s < NS; s++) if (npm[s] < 32) all_hi = 0;
         if (all_hi) for (int s = 0; s < NS; s++) npm[s] -= 32;
`endif
         m_pm = npm;
         m_pred[m_step % HIST] = pr;
         m_step++;
      end
   endtask

   task automatic tick(input bit st, input bit v, input logic [7:0] bm);
      start = st; bm_valid = v; bm_in = bm;
      @(posedge clk);
      model_edge(st, v, bm);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (obs_vec !== 10'h000) $display("FAIL reset_hold: got %h want %h", obs_vec, 10'h000);
      else n_pass++;
      @(negedge clk) reset = 1'b1;
      tick(0, 0, 8'h00);
      n_checks++;
      if (obs_vec !== exp_vec()) $display("FAIL reset_release: got %h want %h", obs_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_all_zero();
      int first_dv;
      first_dv = -1;
      tick(1, 0, 8'h00);
      for (int i = 0; i <= 20; i++) begin
         tick(0, i < 20, 8'b10_10_10_00);
         n_checks++;
         if (obs_vec !== exp_vec()) $display("FAIL zero_model cyc %0d: got %h want %h", i, obs_vec, exp_vec());
         else n_pass++;
         n_checks++;
         if ({dec_bit, best_state, best_pm} !== 9'h000)
            $display("FAIL zero_outputs cyc %0d: got %h want 000", i, {dec_bit, best_state, best_pm});
         else n_pass++;
         if (dec_valid && first_dv < 0) first_dv = i;
      end
      n_checks++;
      if (first_dv !== 11) $display("FAIL zero_first_dv: got %0d want 11", first_dv);
      else n_pass++;
   endtask

   task automatic test_encoded(input bit flip);
      int bits [30];
      int seed_bits [8];
      int es, r, rx;
      logic [7:0] bm;
      seed_bits = '{1, 0, 1, 1, 0, 0, 1, 0};
      for (int i = 0; i < 30; i++) bits[i] = (i < 8) ? seed_bits[i] : 0;
      es = 0;
      tick(1, 0, 8'h00);
      for (int i = 0; i <= 30; i++) begin
         if (i < 30) begin
            r  = (bits[i] << 2) | es;
            rx = 2 * parity(r & 7) + parity(r & 5);
            if (flip && i == 3) rx = rx ^ 2;
            es = r >> 1;
            for (int sy = 0; sy < 4; sy++) bm[sy*2 +: 2] = 2'($countones(sy ^ rx));
            tick(0, 1, bm);
         end else begin
            tick(0, 0, 8'h00);
         end
         n_checks++;
         if (obs_vec !== exp_vec()) $display("FAIL enc_model f%0d cyc %0d: got %h want %h", flip, i, obs_vec, exp_vec());
         else n_pass++;
         n_checks++;
         if (best_pm !== ((flip && i >= 4) ? 6'd1 : 6'd0))
            $display("FAIL enc_best_pm f%0d cyc %0d: got %0d want %0d", flip, i, best_pm, (flip && i >= 4) ? 1 : 0);
         else n_pass++;
         n_checks++;
         if (dec_valid !== (i >= 11)) $display("FAIL enc_dv f%0d cyc %0d: got %b want %b", flip, i, dec_valid, i >= 11);
         else n_pass++;
         if (i >= 11) begin
            n_checks++;
            if (dec_bit !== bits[i-10][0]) $display("FAIL enc_bit f%0d cyc %0d: got %b want %b", flip, i, dec_bit, bits[i-10][0]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_norm();
`ifdef VITERBI_PM_NORM_EN
      bit saw_drop;
      int prev_bpm;
      saw_drop = 0;
      prev_bpm = 0;
`endif
      tick(1, 0, 8'h00);
      for (int i = 0; i <= 40; i++) begin
         tick(0, i < 40, 8'hFF);
         n_checks++;
         if (obs_vec !== exp_vec()) $display("FAIL norm_model cyc %0d: got %h want %h", i, obs_vec, exp_vec());
         else n_pass++;
`ifdef VITERBI_PM_NORM_EN
         if (int'(best_pm) < prev_bpm) saw_drop = 1;
         prev_bpm = int'(best_pm);
`endif
      end
`ifdef VITERBI_PM_NORM_EN
      n_checks++;
      if (saw_drop !== 1'b1) $display("FAIL norm_event: got %b want 1", saw_drop);
      else n_pass++;
`else
      n_checks++;
      if (best_pm !== 6'd63) $display("FAIL norm_saturate: got %0d want 63", best_pm);
      else n_pass++;
`endif
   endtask

   task automatic test_valid_toggle();
      bit pat [4];
      bit prev_v;
      logic [8:0] prev_hold;
      pat = '{1, 0, 0, 1};
      prev_v = 1;
      tick(1, 0, 8'h00);
      prev_hold = {dec_bit, best_state, best_pm};
      for (int i = 0; i < 48; i++) begin
         tick(0, pat[i % 4], 8'($urandom));
         n_checks++;
         if (obs_vec !== exp_vec()) $display("FAIL toggle_model cyc %0d: got %h want %h", i, obs_vec, exp_vec());
         else n_pass++;
         if (!prev_v) begin
            n_checks++;
            if (dec_valid !== 1'b0) $display("FAIL toggle_dv_idle cyc %0d: got %b want 0", i, dec_valid);
            else n_pass++;
            n_checks++;
            if ({dec_bit, best_state, best_pm} !== prev_hold)
               $display("FAIL toggle_hold cyc %0d: got %h want %h", i, {dec_bit, best_state, best_pm}, prev_hold);
            else n_pass++;
         end
         prev_v = pat[i % 4];
         prev_hold = {dec_bit, best_state, best_pm};
      end
   endtask

   task automatic test_reset_start();
      tick(1, 0, 8'h00);
      for (int i = 0; i < 15; i++) begin
         tick(0, 1, 8'($urandom));
         n_checks++;
         if (obs_vec !== exp_vec()) $display("FAIL rs_pre cyc %0d: got %h want %h", i, obs_vec, exp_vec());
         else n_pass++;
      end
      #2 reset = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (obs_vec !== 10'h000) $display("FAIL rs_async: got %h want %h", obs_vec, 10'h000);
      else n_pass++;
      @(negedge clk) reset = 1'b1;
      tick(1, 1, 8'($urandom));
      n_checks++;
      if (obs_vec !== 10'h000) $display("FAIL rs_start: got %h want %h", obs_vec, 10'h000);
      else n_pass++;
      for (int j = 0; j <= 11; j++) begin
         tick(0, 1, 8'($urandom));
         n_checks++;
         if (obs_vec !== exp_vec()) $display("FAIL rs_model cyc %0d: got %h want %h", j, obs_vec, exp_vec());
         else n_pass++;
         n_checks++;
         if (dec_valid !== (j == 11)) $display("FAIL rs_refill cyc %0d: got %b want %b", j, dec_valid, j == 11);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      bit st, v;
      tick(1, 0, 8'h00);
      for (int i = 0; i < 300; i++) begin
         st = ($urandom_range(0, 99) < 3);
         v  = ($urandom_range(0, 3) != 0);
         tick(st, v, 8'($urandom));
         n_checks++;
         if (obs_vec !== exp_vec()) $display("FAIL rand_model cyc %0d: got %h want %h", i, obs_vec, exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_all_zero();
      test_encoded(0);
      test_encoded(1);
      test_norm();
      test_valid_toggle();
      test_reset_start();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
